cart_mapper: RTL

CART_MAPPER -- requirements
Module: cart_mapper

---
 rtl/cart_pkg.sv | 46 ++++
 rtl/cart_hotspot_dec.sv | 56 +++++
 rtl/cart_mapper.sv | 118 +++++++++++
 3 files changed

// File: rtl/cart_pkg.sv
// Shared constants for the cartridge bank mapper: mapper mode codes,
// hotspot base addresses/spans and the bank values loaded on reset.
package cart_pkg;

    typedef enum logic [2:0] {
        MODE_2K  = 3'd0,
        MODE_4K  = 3'd1,
        MODE_F8  = 3'd2,
        MODE_F6  = 3'd3,
        MODE_F4  = 3'd4,
        MODE_E0  = 3'd5,
        MODE_3F  = 3'd6,
        MODE_RSV = 3'd7
    } cart_mode_t;

    localparam logic [11:0] HS_F8_BASE = 12'hFF8;
    localparam logic [11:0] HS_F6_BASE = 12'hFF6;
    localparam logic [11:0] HS_F4_BASE = 12'hFF4;
    localparam logic [11:0] HS_E0_BASE = 12'hFE0;

    localparam logic [11:0] HS_F8_SPAN = 12'd2;
    localparam logic [11:0] HS_F6_SPAN = 12'd4;
    localparam logic [11:0] HS_F4_SPAN = 12'd8;
    localparam logic [11:0] HS_E0_SPAN = 12'd24;

    localparam logic [2:0] RST_BANK_F8    = 3'd1;
    localparam logic [2:0] RST_BANK_F6    = 3'd3;
    localparam logic [2:0] RST_BANK_F4    = 3'd7;
    localparam logic [7:0] RST_BANK_3F    = 8'd0;
    localparam logic [2:0] RST_SLICE_BASE = 3'd4;  // slice n resets to bank 4+n
    localparam logic [2:0] E0_FIXED_BANK  = 3'd7;

    // Slice code the decoder uses for "the single main bank register".
    localparam logic [1:0] SLICE_MAIN = 2'd3;

    function automatic logic [7:0] reset_bank(input logic [2:0] mode);
        case (cart_mode_t'(mode))
            MODE_F8: reset_bank = {5'd0, RST_BANK_F8};
            MODE_F6: reset_bank = {5'd0, RST_BANK_F6};
            MODE_F4: reset_bank = {5'd0, RST_BANK_F4};
            MODE_3F: reset_bank = RST_BANK_3F;
            default: reset_bank = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/cart_hotspot_dec.sv
// Combinational hotspot decode: which bank register an access targets
// (main bank or one of the E0 slices) and the value it would load.
module cart_hotspot_dec
    import cart_pkg::*;
(
    input  logic [2:0]  mode,
    input  logic [12:0] adr,
    input  logic        we,
    input  logic [7:0]  dat,
    output logic        hit,
    output logic [1:0]  slice,
    output logic [7:0]  bank
);

    logic [11:0] ofs_f8;
    logic [11:0] ofs_f6;
    logic [11:0] ofs_f4;
    logic [11:0] ofs_e0;

    // Unsigned wrap makes "below the base" land far above the span.
    assign ofs_f8 = adr[11:0] - HS_F8_BASE;
    assign ofs_f6 = adr[11:0] - HS_F6_BASE;
    assign ofs_f4 = adr[11:0] - HS_F4_BASE;
    assign ofs_e0 = adr[11:0] - HS_E0_BASE;

    always_comb begin
        hit   = 1'b0;
        slice = SLICE_MAIN;
        bank  = 8'd0;
        case (cart_mode_t'(mode))
            MODE_F8: begin
                hit  = (ofs_f8 < HS_F8_SPAN);
                bank = {5'd0, ofs_f8[2:0]};
            end
            MODE_F6: begin
                hit  = (ofs_f6 < HS_F6_SPAN);
                bank = {5'd0, ofs_f6[2:0]};
            end
            MODE_F4: begin
                hit  = (ofs_f4 < HS_F4_SPAN);
                bank = {5'd0, ofs_f4[2:0]};
            end
            MODE_E0: begin
                hit   = (ofs_e0 < HS_E0_SPAN);
                slice = ofs_e0[4:3];
                bank  = {5'd0, ofs_e0[2:0]};
            end
            MODE_3F: begin
                hit  = we && !adr[12] && (adr[7:6] == 2'b00);
                bank = dat;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cart_mapper.sv
// Cartridge bank mapper: holds bank/slice registers and turns the CPU
// address into ROM and SuperChip RAM selects with no added latency.
module cart_mapper
    import cart_pkg::*;
#(
    parameter int ROM_AW    = 15,
    parameter int SC_ENABLE = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_en_i,
    input  logic [15:0]       adr_i,
    input  logic              we_i,
    input  logic [7:0]        dat_i,
    input  logic [2:0]        mode_i,
    input  logic              sc_i,
    output logic [ROM_AW-1:0] rom_adr_o,
    output logic              rom_cs_o,
    output logic [6:0]        ram_adr_o,
    output logic              ram_cs_o,
    output logic              ram_we_o,
    output logic [11:0]       bank_o
);

    logic [2:0]  mode_reg;
    logic [7:0]  bank_reg;
    logic [8:0]  slices;
    logic        mode_change;
    logic        hs_hit;
    logic [1:0]  hs_slice;
    logic [7:0]  hs_bank;
    logic [2:0]  e0_bank;
    logic [18:0] rom_full;
    logic        sc_mode;
    logic        sc_active;
    logic        sc_wr_rng;
    logic        sc_rd_rng;
    logic        unused_bits;

    cart_hotspot_dec u_dec (
        .mode  (mode_reg),
        .adr   (adr_i[12:0]),
        .we    (we_i),
        .dat   (dat_i),
        .hit   (hs_hit),
        .slice (hs_slice),
        .bank  (hs_bank)
    );

    assign mode_change = (mode_i != mode_reg);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_reg <= mode_i;
            bank_reg <= reset_bank(mode_i);
        end else if (mode_change) begin
            mode_reg <= mode_i;
            bank_reg <= reset_bank(mode_i);
        end else if (cpu_en_i && hs_hit && (hs_slice == SLICE_MAIN)) begin
            bank_reg <= hs_bank;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_slice
            logic [2:0] slice_reg;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    slice_reg <= RST_SLICE_BASE + 3'(gi);
                end else if (mode_change) begin
                    slice_reg <= RST_SLICE_BASE + 3'(gi);
                end else if (cpu_en_i && hs_hit && (hs_slice == 2'(gi))) begin
                    slice_reg <= hs_bank[2:0];
                end
            end

            assign slices[gi*3 +: 3] = slice_reg;
        end
    endgenerate

    always_comb begin
        case (adr_i[11:10])
            2'd0:    e0_bank = slices[2:0];
            2'd1:    e0_bank = slices[5:3];
            2'd2:    e0_bank = slices[8:6];
            default: e0_bank = E0_FIXED_BANK;
        endcase
    end

    // Full-width image address; the top bits past ROM_AW simply fall off,
    // which is the wrap-around for oversized bank numbers.
    always_comb begin
        case (cart_mode_t'(mode_reg))
            MODE_2K:                   rom_full = {8'd0, adr_i[10:0]};
            MODE_F8, MODE_F6, MODE_F4: rom_full = {4'd0, bank_reg[2:0], adr_i[11:0]};
            MODE_E0:                   rom_full = {6'd0, e0_bank, adr_i[9:0]};
            MODE_3F:                   rom_full = adr_i[11] ? {8'hFF, adr_i[10:0]}
                                                            : {bank_reg, adr_i[10:0]};
            default:                   rom_full = {7'd0, adr_i[11:0]};
        endcase
    end

    assign sc_mode   = (mode_reg == MODE_F8) || (mode_reg == MODE_F6) || (mode_reg == MODE_F4);
    assign sc_active = (SC_ENABLE != 0) && sc_i && sc_mode;
    assign sc_wr_rng = (adr_i[11:7] == 5'b00000);
    assign sc_rd_rng = (adr_i[11:7] == 5'b00001);

    assign rom_adr_o = rom_full[ROM_AW-1:0];
    assign rom_cs_o  = adr_i[12] && !(sc_active && (sc_wr_rng || sc_rd_rng));
    assign ram_adr_o = adr_i[6:0];
    assign ram_cs_o  = sc_active && sc_rd_rng;
    assign ram_we_o  = sc_active && sc_wr_rng && we_i && cpu_en_i && !rst_i;
    assign bank_o    = {slices, bank_reg[2:0]};

    assign unused_bits = &{1'b0, adr_i[15:13], rom_full[18:ROM_AW]};

endmodule
